aes_state_unload: RTL
=====================

// Module: aes_state_unload
// PURPOSE
//   Reads a completed 128-bit AES state (ciphertext/plaintext) from the round datapath.
//   Streams it out as DATA_W-bit words over a valid/ready interface.
//   Sits between the state register and the narrow output bus (host FIFO / bus slave).
//   Counterpart of the input-side block loader: one 128-bit block in, 128/DATA_W beats out.
// PARAMETERS
//   DATA_W   32   output word width; legal values 8, 16, 32, 64 (must divide 128)
//   NWORDS   128/DATA_W   derived localparam; beats per block
// PORTS
//   clk        in   1        clock, rising-edge
//   rst_n      in   1        reset, asynchronous, active-low
//   blk_valid  in   1        blk_data holds a finished AES state
//   blk_ready  out  1        block accepted when blk_valid && blk_ready at clk edge
//   blk_data   in   128      state to unload; AES byte 0 = blk_data[127:120]
//   out_valid  out  1        out_data/out_last valid
//   out_ready  in   1        sink accepts beat when out_valid && out_ready at clk edge
//   out_data   out  DATA_W   current word
//   out_last   out  1        high with final word of a block
//   busy       out  1        block held, beats outstanding
// BEHAVIOUR
//   - Reset: out_valid=0, out_last=0, busy=0, out_data=0, beat counter=0, holding reg=0.
//   - FSM IDLE/SEND, registered.
//   - IDLE:
//     - blk_ready=1.
//     - On blk accept: latch blk_data into 128-bit holding reg, counter=0, go SEND.
//   - SEND:
//     - out_valid=1, busy=1.
//     - out_data = word[counter] of holding reg; out_last = (counter==NWORDS-1).
//   - Latency: block accepted at edge N -> first word valid in the cycle after edge N.
//   - Beat accept (out_valid && out_ready) with counter<NWORDS-1: counter+1.
//   - Beat accept with counter==NWORDS-1:
//     - blk_ready=1 combinationally in that cycle (blk_ready = IDLE | (SEND & out_ready & out_last)).
//     - If blk_valid: load the new block, stay SEND, counter=0 (back-to-back, no bubble).
//     - Else: go IDLE.
//   - Handshake:
//     - out_data/out_last stable while out_valid && !out_ready.
//     - out_valid never drops before the beat is accepted.
//     - out_valid does not depend combinationally on out_ready.
//   - blk_data ignored outside accept cycles; the holding reg isolates the datapath, so the
//     state register may change immediately after the accept.
//   - Counter width = clog2(NWORDS), minimum 1 bit.
//     - Wraps to 0 only via the last-beat rule.
//     - Never exceeds NWORDS-1.
//   - DATA_W=128 is illegal (not listed); other illegal values -> $error at elaboration.
//   - Reset mid-block: asynchronous return to IDLE, outputs to reset values, partial block
//     discarded, no further beats.
// CONFIGURATION
//   - AES_UNLOAD_LSB_FIRST_EN undefined (default):
//     - MSB-first; word k = hold[127-k*DATA_W -: DATA_W].
//     - AES byte 0 goes out first.
//   - AES_UNLOAD_LSB_FIRST_EN defined:
//     - LSB-first; word k = hold[k*DATA_W +: DATA_W].
//     - Byte order within a word unchanged.
//     - Handshake and timing identical.
// TESTING
//   1. DATA_W=32, blk=00112233_44556677_8899AABB_CCDDEEFF, out_ready=1 ->
//      beats 00112233, 44556677, 8899AABB, CCDDEEFF on 4 consecutive cycles, out_last on beat 4 only.
//   2. Same block, out_ready toggling 1,0,0,1,... ->
//      exactly 4 beats, data held stable during stalls, no duplicate or dropped words.
//   3. Two blocks, blk_valid held high, out_ready=1 ->
//      8 beats with no idle cycle between beat 4 and beat 5; blk_ready high only in IDLE and
//      the last-beat cycle.
//   4. rst_n low after beat 2 of a 4-beat block -> out_valid/busy=0 immediately;
//      after release, a new block unloads from word 0.
//   5. DATA_W=8, blk=000102..0F (byte 0=00) -> 16 beats 00..0F, out_last on 0F;
//      with AES_UNLOAD_LSB_FIRST_EN -> 0F..00, out_last on 00.
//   6. blk_valid pulsed while SEND mid-block -> ignored, blk_ready=0;
//      the holding reg is unchanged and the current block completes intact.

Source files
------------

// File: rtl/aes_state_unload_if.sv
// rtl/aes_state_unload_if.sv - block-in / word-out handshake bundle for aes_state_unload
interface aes_state_unload_if #(
  parameter int DATA_W = 32
);
  logic              blk_valid;
  logic              blk_ready;
  logic [127:0]      blk_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport master (
    output blk_valid, blk_data, out_ready,
    input  blk_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  blk_valid, blk_data, out_ready,
    output blk_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/aes_state_unload.sv
// rtl/aes_state_unload.sv - unloads a 128-bit AES state as DATA_W-bit beats
// Optional AES_UNLOAD_LSB_FIRST_EN: emit the least-significant word first.
module aes_state_unload #(
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_state_unload_if.slave  bus
);
  localparam int NWORDS = 128 / DATA_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  generate
    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
      $error("aes_state_unload: DATA_W must be 8, 16, 32 or 64");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [127:0]      hold;
  logic [CNT_W-1:0]  cnt;
  logic              out_valid_q;
  logic              out_last_q;
  logic              busy_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              blk_ready_c;

  function automatic logic [DATA_W-1:0] word_of(input logic [127:0] blk, input logic [CNT_W-1:0] k);
    logic [127:0] s;
`ifdef AES_UNLOAD_LSB_FIRST_EN
    s = blk >> (int'(k) * DATA_W);
    return s[DATA_W-1:0];
`else
    s = blk << (int'(k) * DATA_W);
    return s[127 -: DATA_W];
`endif
  endfunction

  assign cnt_nxt = cnt + 1'b1;

  // Last-beat acceptance reopens the block port so a waiting block loads with no bubble.
  assign blk_ready_c   = (state == IDLE) || ((state == SEND) && bus.out_ready && out_last_q);
  assign bus.blk_ready = blk_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold        <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.blk_valid) begin
            hold        <= bus.blk_data;
            cnt         <= '0;
            out_data_q  <= word_of(bus.blk_data, '0);
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (!out_last_q) begin
              cnt        <= cnt_nxt;
              out_data_q <= word_of(hold, cnt_nxt);
              out_last_q <= (cnt_nxt == LAST_IDX);
            end else if (bus.blk_valid) begin
              hold       <= bus.blk_data;
              cnt        <= '0;
              out_data_q <= word_of(bus.blk_data, '0);
              out_last_q <= 1'b0;
            end else begin
              cnt         <= '0;
              out_last_q  <= 1'b0;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
